// File: rtl/hdmi_pkg.sv
// Shared HDMI pipeline definitions: packed pixel bus, frame geometry and the
// reciprocal-unit widths used by the white-balance gain path.
package hdmi_pkg;

    localparam int AVG_W   = 8;
    localparam int RECIP_W = 32;
    localparam int PACK_W  = 50;
    localparam int H_ACT   = 1280;
    localparam int V_ACT   = 720;

    typedef struct packed {
        logic        clk;
        logic        href;
        logic        hsync;
        logic        vsync;
        logic        de;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic [10:0] x;
        logic [9:0]  y;
    } hdmi_pack_t;

    function automatic logic [PACK_W-1:0] hdmi_pack(
        input logic        clk_b,
        input logic        href,
        input logic        hsync,
        input logic        vsync,
        input logic        de,
        input logic [7:0]  r,
        input logic [7:0]  g,
        input logic [7:0]  b,
        input logic [10:0] x,
        input logic [9:0]  y
    );
        hdmi_pack_t s;
        s.clk   = clk_b;
        s.href  = href;
        s.hsync = hsync;
        s.vsync = vsync;
        s.de    = de;
        s.r     = r;
        s.g     = g;
        s.b     = b;
        s.x     = x;
        s.y     = y;
        return s;
    endfunction

    function automatic hdmi_pack_t hdmi_unpack(input logic [PACK_W-1:0] v);
        hdmi_pack_t s;
        s = v;
        return s;
    endfunction

endpackage

// File: rtl/recip_div_step.sv
// One restoring-division step: shift the remainder left by one (bringing down
// a zero numerator bit) and subtract the divisor when it fits.
module recip_div_step #(
    parameter int W = 8
) (
    input  logic [W:0]   rem_in,
    input  logic [W-1:0] div,
    output logic [W:0]   rem_out,
    output logic         q_bit
);

    logic [W+1:0] w_shift;
    logic [W:0]   w_diff;

    assign w_shift = {rem_in, 1'b0};
    assign q_bit   = (w_shift >= {2'b00, div});
    // When q_bit is set the true difference is below div, so W+1 bits hold it.
    assign w_diff  = w_shift[W:0] - {1'b0, div};
    assign rem_out = q_bit ? w_diff : w_shift[W:0];

endmodule

// File: rtl/avg_reciprocal_unit.sv
// Iterative reciprocal floor(2^RECIP_W / avg), one quotient bit per cycle.
// Optional round-to-nearest on the final quotient with `define RECIP_ROUND_EN.
module avg_reciprocal_unit
    import hdmi_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [AVG_W-1:0]   avg,
    output logic               busy,
    output logic               valid,
    output logic [RECIP_W-1:0] recip
);

    localparam int CNT_W = $clog2(RECIP_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(RECIP_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [AVG_W-1:0]   r_div;
    logic [AVG_W:0]     r_rem;
    logic [RECIP_W-1:0] r_quot;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sat;

    logic [AVG_W:0]     w_rem_next;
    logic               w_q_bit;
    logic [RECIP_W-1:0] w_result;

    recip_div_step #(
        .W (AVG_W)
    ) u_step (
        .rem_in  (r_rem),
        .div     (r_div),
        .rem_out (w_rem_next),
        .q_bit   (w_q_bit)
    );

`ifdef RECIP_ROUND_EN
    logic w_round_up;
    assign w_round_up = ({r_rem, 1'b0} >= {2'b00, r_div});

    // Final quotient: saturate for avg<2, otherwise round half up without wrapping.
    always_comb begin
        w_result = r_quot;
        if (r_sat) begin
            w_result = '1;
        end else if (w_round_up && (r_quot != '1)) begin
            w_result = r_quot + RECIP_W'(1);
        end else begin
            w_result = r_quot;
        end
    end
`else
    // Final quotient: saturate for avg<2 (2^RECIP_W does not fit), else floor.
    always_comb begin
        w_result = r_quot;
        if (r_sat) begin
            w_result = '1;
        end else begin
            w_result = r_quot;
        end
    end
`endif

    // Control FSM and datapath registers; the numerator's leading 1 seeds the remainder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_rem   <= '0;
            r_quot  <= '0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            recip   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    valid <= 1'b0;
                    if (start) begin
                        r_div   <= avg;
                        r_rem   <= {{AVG_W{1'b0}}, 1'b1};
                        r_quot  <= '0;
                        r_cnt   <= '0;
                        r_sat   <= (avg < AVG_W'(2));
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_rem  <= w_rem_next;
                    r_quot <= {r_quot[RECIP_W-2:0], w_q_bit};
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == LAST_STEP) begin
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_DONE: begin
                    recip   <= w_result;
                    valid   <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    valid   <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avg_reciprocal_unit.sv
// Directed bench for avg_reciprocal_unit: exact values, saturation, busy
// protocol, mid-run reset and a full 1..255 sweep.
module tb_avg_reciprocal_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  avg = 8'd0;
    logic        busy;
    logic        valid;
    logic [31:0] recip;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    avg_reciprocal_unit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .avg   (avg),
        .busy  (busy),
        .valid (valid),
        .recip (recip)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] golden(input int a);
        longint unsigned n;
        longint unsigned q;
        longint unsigned r;
        n = 64'h1_0000_0000;
        if (a < 2) return 32'hFFFF_FFFF;
        q = n / longint'(a);
        r = n % longint'(a);
`ifdef RECIP_ROUND_EN
        if (2 * r >= longint'(a)) q = q + 1;
`endif
        if (r == 64'hFFFF_FFFF_FFFF_FFFF) q = q + 0;
        return q[31:0];
    endfunction

    // Start one division, then track latency, result and recip stability.
    task automatic run_div(input logic [7:0] a, input logic [31:0] exp, input string tag);
        int          lat;
        int          unstable;
        logic [31:0] held;
        @(negedge clk);
        held  = recip;
        start = 1'b1;
        avg   = a;
        @(posedge clk);
        #1;
        start = 1'b0;
        avg   = ~a;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        lat      = 0;
        unstable = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (valid) break;
            if (recip !== held) unstable++;
        end
        check({tag, "_lat"}, 64'(lat), 64'd33);
        check({tag, "_recip"}, 64'(recip), 64'(exp));
        check({tag, "_stable"}, 64'(unstable), 64'd0);
    endtask

    // Start a division on a0, then hold start high with a1 for cycles lo..hi after accept.
    task automatic drive_run(input logic [7:0] a0, input int lo, input int hi, input logic [7:0] a1,
                             output int lat1, output int lat2, output int npulse,
                             output logic [31:0] v1, output logic [31:0] v2,
                             output logic b33, output logic b34);
        lat1 = 0; lat2 = 0; npulse = 0; v1 = '0; v2 = '0; b33 = 1'bx; b34 = 1'bx;
        @(negedge clk);
        start = 1'b1;
        avg   = a0;
        @(posedge clk);
        #1;
        start = 1'b0;
        avg   = 8'h5A;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (k >= lo && k <= hi) begin
                start = 1'b1;
                avg   = a1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (k == 33) b33 = busy;
            if (k == 34) b34 = busy;
            if (valid) begin
                npulse++;
                if (npulse == 1) begin
                    lat1 = k;
                    v1   = recip;
                end else begin
                    lat2 = k;
                    v2   = recip;
                end
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int          lat1, lat2, npulse, pulses;
        logic [31:0] v1, v2;
        logic        b33, b34;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_recip", 64'(recip), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_div(8'd128, 32'h0200_0000, "avg128");

        // Mid-run reset on avg=5: aborts with no pulse and clears recip.
        @(negedge clk);
        start = 1'b1;
        avg   = 8'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_recip", 64'(recip), 64'd0);
        check("midrst_valid", 64'(valid), 64'd0);
        @(posedge clk);
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (valid) pulses++;
        end
        check("midrst_nopulse", 64'(pulses), 64'd0);

        run_div(8'd2,   32'h8000_0000, "avg2");
        run_div(8'd255, 32'h0101_0101, "avg255");
        run_div(8'd3,   32'h5555_5555, "avg3");
`ifdef RECIP_ROUND_EN
        run_div(8'd7,   32'h2492_4925, "avg7");
`else
        run_div(8'd7,   32'h2492_4924, "avg7");
`endif
        run_div(8'd0,   32'hFFFF_FFFF, "avg0");
        run_div(8'd1,   32'hFFFF_FFFF, "avg1");

        // start at N+5 with avg=9 during a run on 128 is ignored.
        drive_run(8'd128, 5, 5, 8'd9, lat1, lat2, npulse, v1, v2, b33, b34);
        check("busyig_pulses", 64'(npulse), 64'd1);
        check("busyig_lat", 64'(lat1), 64'd33);
        check("busyig_recip", 64'(v1), 64'h0200_0000);
        check("busyig_b34", 64'(b34), 64'd0);

        // start held across the edge busy falls: accepted one cycle later.
        drive_run(8'd3, 33, 34, 8'd2, lat1, lat2, npulse, v1, v2, b33, b34);
        check("edge_pulses", 64'(npulse), 64'd2);
        check("edge_lat1", 64'(lat1), 64'd33);
        check("edge_recip1", 64'(v1), 64'h5555_5555);
        check("edge_b33", 64'(b33), 64'd0);
        check("edge_b34", 64'(b34), 64'd1);
        check("edge_lat2", 64'(lat2), 64'd67);
        check("edge_recip2", 64'(v2), 64'h8000_0000);

        for (int a = 1; a <= 255; a++) begin
            run_div(8'(a), golden(a), $sformatf("sweep%0d", a));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
